// File: rtl/gpio_input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// gpio_input_conditioner_pkg
// Shared definitions for the GPIO input conditioner: edge-mode encodings,
// control register bit positions and the reserved-bit mask of the control
// register.
// -----------------------------------------------------------------------------
package gpio_input_conditioner_pkg;

  typedef enum logic [1:0] {
    EDGE_ANY  = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_RISE = 2'b10,
    EDGE_NONE = 2'b11
  } edge_mode_e;

  localparam int EDGE_MODE_LSB = 0;
  localparam int DB_EN_BIT     = 7;

  // Bits 6:2 are not stored and always read back as 0.
  localparam logic [7:0] CTRL_RESERVED_MASK = 8'h7C;

endpackage

// File: rtl/gpio_input_conditioner_pin_debounce.sv
// -----------------------------------------------------------------------------
// pin_debounce
// Single-bit conditioner: SYNC_STAGES-deep synchroniser followed by a
// persistence filter. A new synchronised level must be seen on
// DEBOUNCE_CYCLES consecutive edges before it is accepted into 'stable'.
// With bypass high the filter is skipped and the counter is held at 0.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   pin_async in   raw pin level, asynchronous to clk
//   bypass    in   1: stable follows the synchroniser output every edge
//   stable    out  conditioned level
// -----------------------------------------------------------------------------
module pin_debounce
  import gpio_input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_async,
  input  logic bypass,
  output logic stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CNT_W-1:0]       cnt_q;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_async};
      if (bypass) begin
        // Any partial count is discarded when switching into bypass.
        stable <= sync;
        cnt_q  <= '0;
      end else if (sync == stable) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        stable <= sync;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/gpio_input_conditioner.sv
// -----------------------------------------------------------------------------
// gpio_input_conditioner
// Conditions asynchronous external pin levels into the PIN register value,
// detects configurable edges on the conditioned level, latches them into a
// write-1-to-clear flag register and raises irq for unmasked flags.
//
// Ports:
//   clk                in   system clock
//   reset              in   asynchronous, active-high reset
//   pin_input_data     in   raw pin levels (WIDTH), asynchronous to clk
//   mask_write_enable  in   mask register write strobe
//   mask_input         in   mask write data (WIDTH)
//   ctrl_write_enable  in   control register write strobe
//   ctrl_input         in   control write data (8): [1:0] edge mode, [7] DB_EN
//   flag_write_enable  in   flag register write strobe (write-1-to-clear)
//   flag_input         in   flag clear data (WIDTH)
//   pin_output         out  conditioned pin value
//   mask_output        out  mask register
//   ctrl_output        out  control register (reserved bits read 0)
//   flag_output        out  edge flag register
//   irq                out  OR of (flag_output AND mask_output)
// -----------------------------------------------------------------------------
module gpio_input_conditioner
  import gpio_input_conditioner_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_input_data,
  input  logic             mask_write_enable,
  input  logic [WIDTH-1:0] mask_input,
  input  logic             ctrl_write_enable,
  input  logic [7:0]       ctrl_input,
  input  logic             flag_write_enable,
  input  logic [WIDTH-1:0] flag_input,
  output logic [WIDTH-1:0] pin_output,
  output logic [WIDTH-1:0] mask_output,
  output logic [7:0]       ctrl_output,
  output logic [WIDTH-1:0] flag_output,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] mask_q;
  logic [7:0]       ctrl_q;
  logic [WIDTH-1:0] flag_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] clr;
  logic             bypass;
  edge_mode_e       edge_mode;

  assign bypass    = ~ctrl_q[DB_EN_BIT];
  assign edge_mode = edge_mode_e'(ctrl_q[EDGE_MODE_LSB +: 2]);

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    pin_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_pin_debounce (
      .clk       (clk),
      .reset     (reset),
      .pin_async (pin_input_data[i]),
      .bypass    (bypass),
      .stable    (stable[i])
    );
  end

  always_comb begin
    rise = stable & ~stable_d;
    fall = ~stable & stable_d;
    clr  = flag_write_enable ? flag_input : '0;
    case (edge_mode)
      EDGE_ANY:  evt = rise | fall;
      EDGE_FALL: evt = fall;
      EDGE_RISE: evt = rise;
      default:   evt = '0;
    endcase
  end

  // Edge-detect delay stage and register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_d <= '0;
      mask_q   <= '0;
      ctrl_q   <= '0;
      flag_q   <= '0;
    end else begin
      stable_d <= stable;
      if (mask_write_enable) mask_q <= mask_input;
      if (ctrl_write_enable) ctrl_q <= ctrl_input & ~CTRL_RESERVED_MASK;
      // OR-ing the new events after the clear lets a same-cycle set win.
      flag_q <= (flag_q & ~clr) | evt;
    end
  end

  assign pin_output  = stable;
  assign mask_output = mask_q;
  assign ctrl_output = ctrl_q;
  assign flag_output = flag_q;
  assign irq         = |(flag_q & mask_q);

endmodule

// File: tb/tb_gpio_input_conditioner.sv
module tb_gpio_input_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pin_input_data;
  logic       mask_write_enable;
  logic [7:0] mask_input;
  logic       ctrl_write_enable;
  logic [7:0] ctrl_input;
  logic       flag_write_enable;
  logic [7:0] flag_input;
  logic [7:0] pin_output;
  logic [7:0] mask_output;
  logic [7:0] ctrl_output;
  logic [7:0] flag_output;
  logic       irq;

  int total = 0;
  int bad   = 0;

  gpio_input_conditioner #(
    .WIDTH           (8),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .pin_input_data    (pin_input_data),
    .mask_write_enable (mask_write_enable),
    .mask_input        (mask_input),
    .ctrl_write_enable (ctrl_write_enable),
    .ctrl_input        (ctrl_input),
    .flag_write_enable (flag_write_enable),
    .flag_input        (flag_input),
    .pin_output        (pin_output),
    .mask_output       (mask_output),
    .ctrl_output       (ctrl_output),
    .flag_output       (flag_output),
    .irq               (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_ctrl(input logic [7:0] v);
    ctrl_write_enable = 1'b1;
    ctrl_input        = v;
    tick();
    ctrl_write_enable = 1'b0;
  endtask

  task automatic wr_flag(input logic [7:0] v);
    flag_write_enable = 1'b1;
    flag_input        = v;
    tick();
    flag_write_enable = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    pin_input_data    = 8'h00;
    mask_write_enable = 1'b0;
    mask_input        = 8'h00;
    ctrl_write_enable = 1'b0;
    ctrl_input        = 8'h00;
    flag_write_enable = 1'b0;
    flag_input        = 8'h00;
    tick(2);
    check("rst_pin",  pin_output,  8'h00);
    check("rst_mask", mask_output, 8'h00);
    check("rst_ctrl", ctrl_output, 8'h00);
    check("rst_flag", flag_output, 8'h00);
    check("rst_irq",  irq,         1'b0);
    reset = 1'b0;
    tick();

    // 1: bypass, rising edges, mask pin 0
    ctrl_write_enable = 1'b1; ctrl_input = 8'h02;
    mask_write_enable = 1'b1; mask_input = 8'h01;
    tick();
    ctrl_write_enable = 1'b0; mask_write_enable = 1'b0;
    check("t1_ctrl", ctrl_output, 8'h02);
    check("t1_mask", mask_output, 8'h01);
    pin_input_data = 8'h01;
    tick(2);
    check("t1_pin_e2", pin_output, 8'h00);
    tick();
    check("t1_pin_e3", pin_output, 8'h01);
    check("t1_flag_e3", flag_output, 8'h00);
    tick();
    check("t1_flag_e4", flag_output, 8'h01);
    check("t1_irq_e4", irq, 1'b1);
    wr_flag(8'h01);
    check("t1_flag_clr", flag_output, 8'h00);
    check("t1_irq_clr", irq, 1'b0);

    // 2: debounce on, 3-cycle glitch on pin 3 is rejected
    wr_ctrl(8'h82);
    pin_input_data = 8'h09;
    tick(3);
    pin_input_data = 8'h01;
    tick(8);
    check("t2_glitch_pin", pin_output, 8'h01);
    check("t2_glitch_flag", flag_output, 8'h00);
    pin_input_data = 8'h09;
    tick(5);
    check("t2_pin_e5", pin_output, 8'h01);
    tick();
    check("t2_pin_e6", pin_output, 8'h09);
    tick();
    check("t2_flag", flag_output, 8'h08);
    check("t2_irq", irq, 1'b0);
    tick(3);
    wr_flag(8'h08);
    check("t2_flag_clr", flag_output, 8'h00);

    // 3: falling-edge mode, all pins unmasked
    wr_ctrl(8'h83);
    pin_input_data = 8'h00;
    tick(8);
    check("t3_pin_zero", pin_output, 8'h00);
    check("t3_flag_none", flag_output, 8'h00);
    ctrl_write_enable = 1'b1; ctrl_input = 8'h81;
    mask_write_enable = 1'b1; mask_input = 8'hFF;
    tick();
    ctrl_write_enable = 1'b0; mask_write_enable = 1'b0;
    pin_input_data = 8'hA5;
    tick(8);
    check("t3_pin_a5", pin_output, 8'hA5);
    check("t3_flag_rise", flag_output, 8'h00);
    check("t3_irq_rise", irq, 1'b0);
    pin_input_data = 8'h00;
    tick(6);
    check("t3_pin_fall", pin_output, 8'h00);
    tick();
    check("t3_flag_fall", flag_output, 8'hA5);
    check("t3_irq_fall", irq, 1'b1);
    wr_flag(8'hFF);
    check("t3_flag_clr", flag_output, 8'h00);

    // 4: set beats clear on the same bit in the same cycle
    wr_ctrl(8'h00);
    pin_input_data = 8'h03;
    tick(3);
    check("t4_pin_03", pin_output, 8'h03);
    tick();
    check("t4_flag_03", flag_output, 8'h03);
    pin_input_data = 8'h02;
    tick(3);
    check("t4_pin_02", pin_output, 8'h02);
    wr_flag(8'h01);
    check("t4_set_wins", flag_output, 8'h03);
    tick();
    wr_flag(8'h02);
    check("t4_clr_bit1", flag_output, 8'h01);
    check("t4_irq", irq, 1'b1);

    // 5: reserved bits, then mode NONE
    wr_ctrl(8'hFE);
    check("t5_ctrl_fe", ctrl_output, 8'h82);
    ctrl_write_enable = 1'b1; ctrl_input = 8'h03;
    flag_write_enable = 1'b1; flag_input = 8'hFF;
    tick();
    ctrl_write_enable = 1'b0; flag_write_enable = 1'b0;
    check("t5_flag_clr", flag_output, 8'h00);
    pin_input_data = 8'h5A;
    tick(3);
    check("t5_pin_5a", pin_output, 8'h5A);
    tick(2);
    check("t5_flag_5a", flag_output, 8'h00);
    pin_input_data = 8'h0F;
    tick(3);
    check("t5_pin_0f", pin_output, 8'h0F);
    tick(2);
    check("t5_flag_0f", flag_output, 8'h00);
    check("t5_irq", irq, 1'b0);

    // 6: asynchronous reset mid-debounce
    ctrl_write_enable = 1'b1; ctrl_input = 8'h80;
    pin_input_data    = 8'hFF;
    tick();
    ctrl_write_enable = 1'b0;
    tick(2);
    check("t6_pin_pre", pin_output, 8'h0F);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_pin",  pin_output,  8'h00);
    check("t6_rst_mask", mask_output, 8'h00);
    check("t6_rst_ctrl", ctrl_output, 8'h00);
    check("t6_rst_flag", flag_output, 8'h00);
    check("t6_rst_irq",  irq,         1'b0);
    tick(2);
    reset = 1'b0;
    tick(2);
    check("t6_pin_e2", pin_output, 8'h00);
    tick();
    check("t6_pin_e3", pin_output, 8'hFF);
    tick();
    check("t6_flag_e4", flag_output, 8'hFF);
    check("t6_irq_e4", irq, 1'b0);
    tick(2);
    check("t6_pin_e6", pin_output, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
